solver_job_ctrl: RTL and testbench



---
 rtl/solver_pkg.sv | 30 +++
 rtl/job_word_assembler.sv | 42 ++++
 rtl/solver_job_ctrl.sv | 144 ++++++++++++++
 tb/tb_solver_job_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/solver_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// solver_pkg : shared constants and types for the solver front end
// Revision   : 1.0
// ------------------------------------------------------------------
package solver_pkg;

  localparam logic [2:0] SOLVER_FOUND     = 3'h4;
  localparam logic [2:0] SOLVER_EXHAUSTED = 3'h5;

  localparam int JOB_WORDS = 19;
  localparam int JOB_BITS  = 32 * JOB_WORDS;

  typedef enum logic [1:0] {
    RES_FOUND     = 2'd0,
    RES_EXHAUSTED = 2'd1,
    RES_TIMEOUT   = 2'd2,
    RES_ABORTED   = 2'd3
  } res_code_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    HOLD   = 3'd2,
    RUN    = 3'd3,
    REPORT = 3'd4
  } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/job_word_assembler.sv
`default_nettype none
// ------------------------------------------------------------------
// job_word_assembler : word counter and 608-bit job shift register
// Revision           : 1.0
// ------------------------------------------------------------------
module job_word_assembler
  import solver_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                clear,
  input  logic [31:0]         word,
  output logic [JOB_BITS-1:0] job,
  output logic                done
);

  localparam logic [4:0] LAST_WORD = 5'(JOB_WORDS - 1);

  logic [4:0] count;

  assign done = load && (count == LAST_WORD);

  // Shifting in from the bottom leaves word 0 in the top 32 bits after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      job   <= '0;
    end else begin
      if (clear || done) begin
        count <= '0;
      end else if (load) begin
        count <= count + 5'd1;
      end
      if (load) begin
        job <= {job[JOB_BITS-33:0], word};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/solver_job_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// solver_job_ctrl : loads a job into block_solver and reports its verdict
// Revision        : 1.0
// ------------------------------------------------------------------
module solver_job_ctrl
  import solver_pkg::*;
#(
  parameter int unsigned       RST_HOLD   = 2,
  parameter int unsigned       WDOG_W     = 32,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(32'hFFFF_FFFF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         abort,
  output logic [255:0] midstate,
  output logic [255:0] target,
  output logic [95:0]  header_leftovers,
  output logic         solver_rst_n,
  input  logic [2:0]   solver_state,
  input  logic [31:0]  solver_nonce,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [1:0]   res_code,
  output logic [31:0]  res_nonce,
  output logic [7:0]   res_job_id
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_LOAD   = LOAD;
  localparam logic [2:0] S_HOLD   = HOLD;
  localparam logic [2:0] S_RUN    = RUN;
  localparam logic [2:0] S_REPORT = REPORT;

  localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_LIMIT - WDOG_W'(1);

  logic [2:0]          state;
  logic [2:0]          state_n;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [WDOG_W-1:0]   wdog;
  logic                accept;
  logic                load_en;
  logic                clear_job;
  logic                asm_done;
  logic                term;
  res_code_e           term_code;
  logic [JOB_BITS-1:0] job;

  assign accept    = in_valid && in_ready;
  assign load_en   = accept && !(state == S_LOAD && abort);
  assign clear_job = abort && (state == S_LOAD || state == S_HOLD);

  job_word_assembler u_asm (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_en),
    .clear (clear_job),
    .word  (in_data),
    .job   (job),
    .done  (asm_done)
  );

  assign midstate         = job[JOB_BITS-1 -: 256];
  assign target           = job[JOB_BITS-257 -: 256];
  assign header_leftovers = job[95:0];

  always_comb begin
    state_n   = state;
    term      = 1'b0;
    term_code = RES_ABORTED;
    case (state)
      S_IDLE: begin
        if (accept) state_n = S_LOAD;
      end
      S_LOAD: begin
        if (abort) state_n = S_REPORT;
        else if (asm_done) state_n = S_HOLD;
      end
      S_HOLD: begin
        if (abort) state_n = S_REPORT;
        else if (hold_cnt == HOLD_LAST) state_n = S_RUN;
      end
      S_RUN: begin
        // Abort outranks any solver verdict, and a verdict outranks the watchdog.
        term = 1'b1;
        if (abort) begin
          term_code = RES_ABORTED;
        end else if (solver_state == SOLVER_FOUND) begin
          term_code = RES_FOUND;
        end else if (solver_state == SOLVER_EXHAUSTED) begin
          term_code = RES_EXHAUSTED;
        end else if ((WDOG_LIMIT != '0) && (wdog == WDOG_LAST)) begin
          term_code = RES_TIMEOUT;
        end else begin
          term = 1'b0;
        end
        if (term) state_n = S_REPORT;
      end
      S_REPORT: begin
        if (res_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake and solver-reset outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      solver_rst_n <= 1'b0;
      res_valid    <= 1'b0;
      res_code     <= '0;
      res_nonce    <= '0;
      res_job_id   <= '0;
      hold_cnt     <= '0;
      wdog         <= '0;
    end else begin
      state        <= state_n;
      in_ready     <= (state_n == S_IDLE) || (state_n == S_LOAD);
      solver_rst_n <= (state_n == S_RUN);
      res_valid    <= (state_n == S_REPORT);
      hold_cnt     <= (state == S_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
      wdog         <= (state == S_RUN) ? wdog + WDOG_W'(1) : '0;
      if (term) begin
        res_code  <= term_code;
        res_nonce <= solver_nonce;
      end else if (clear_job) begin
        res_code  <= RES_ABORTED;
        res_nonce <= '0;
      end
      if (state == S_REPORT && res_ready) begin
        res_job_id <= res_job_id + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_solver_job_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_solver_job_ctrl : randomized self-checking bench for solver_job_ctrl
// Revision           : 1.0
// ------------------------------------------------------------------
module tb_solver_job_ctrl;
  import solver_pkg::*;

  localparam int RST_HOLD = 2;
  localparam int LIMIT    = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         abort = 1'b0;
  logic [255:0] midstate;
  logic [255:0] target;
  logic [95:0]  header_leftovers;
  logic         solver_rst_n;
  logic [2:0]   solver_state = '0;
  logic [31:0]  solver_nonce = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [1:0]   res_code;
  logic [31:0]  res_nonce;
  logic [7:0]   res_job_id;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_id  = 0;
  logic [31:0] jw [JOB_WORDS];

  solver_job_ctrl #(
    .RST_HOLD   (RST_HOLD),
    .WDOG_W     (32),
    .WDOG_LIMIT (32'(LIMIT))
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .abort            (abort),
    .midstate         (midstate),
    .target           (target),
    .header_leftovers (header_leftovers),
    .solver_rst_n     (solver_rst_n),
    .solver_state     (solver_state),
    .solver_nonce     (solver_nonce),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_code         (res_code),
    .res_nonce        (res_nonce),
    .res_job_id       (res_job_id)
  );

  always #5 clk = ~clk;

  // Job layout: word i lands in bits [607-32i -: 32] of {midstate, target, leftovers}.
  function automatic logic [607:0] exp_job();
    logic [607:0] v = '0;
    for (int i = 0; i < JOB_WORDS; i++) v[607-32*i -: 32] = jw[i];
    return v;
  endfunction

  task automatic random_job();
    for (int i = 0; i < JOB_WORDS; i++) jw[i] = $urandom;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    bit acc = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    for (int c = 0; c < 50 && !acc; c++) begin
      acc = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_word: in_ready stayed %b for 50 cycles, required 1", in_ready);
    end
  endtask

  // kind: 0 found, 1 exhausted, 2 solver never finishes, 3 abort in RUN,
  //       4 abort in HOLD, 5 abort in LOAD after word dly
  task automatic run_job(input int kind, input int dly, input int rd, input bit gaps,
                         input logic [31:0] tnonce);
    int          n_words;
    int          holds;
    int          term_k;
    int          rc;
    bit          is_abort;
    logic [1:0]  ecode;
    logic [31:0] enonce;
    logic [31:0] nk;
    n_words   = (kind == 5) ? dly + 1 : JOB_WORDS;
    res_ready = 1'b0;
    ecode     = 2'd3;
    enonce    = '0;
    for (int i = 0; i < n_words; i++) send_word(jw[i], gaps);

    if (kind == 4 || kind == 5) begin
      if (kind == 4) begin
        n_tests++;
        if ({midstate, target, header_leftovers} !== exp_job()) begin
          n_fail++;
          $display("FAIL job_fields: got %h required %h", {midstate, target, header_leftovers}, exp_job());
        end
      end
      res_ready = (rd == 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end else begin
      n_tests++;
      if ({midstate, target, header_leftovers} !== exp_job()) begin
        n_fail++;
        $display("FAIL job_fields: got %h required %h", {midstate, target, header_leftovers}, exp_job());
      end
      n_tests++;
      if (in_ready !== 1'b0 || solver_rst_n !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_entry: in_ready=%b solver_rst_n=%b, required 0 0", in_ready, solver_rst_n);
      end
      holds = 0;
      while (solver_rst_n !== 1'b1 && holds < 20) begin
        holds++;
        @(negedge clk);
      end
      n_tests++;
      if (holds != RST_HOLD) begin
        n_fail++;
        $display("FAIL hold_cycles: solver_rst_n low for %0d cycles, required %0d", holds, RST_HOLD);
      end
      res_ready = (rd == 0);
      term_k = -1;
      for (int k = 0; k < LIMIT + 4 && term_k < 0; k++) begin
        nk = $urandom;
        rc = $urandom_range(0, 5);
        if (rc >= 4) rc += 2;
        solver_state = (kind == 2) ? 3'd1 : 3'(rc);
        is_abort = (kind == 3 && k == dly);
        if (k == dly && (kind == 0 || kind == 3)) solver_state = SOLVER_FOUND;
        if (k == dly && kind == 1) solver_state = SOLVER_EXHAUSTED;
        if (k == dly && kind != 3) nk = tnonce;
        solver_nonce = nk;
        abort = is_abort;
        if (is_abort) begin
          term_k = k; ecode = 2'd3;
        end else if (solver_state == SOLVER_FOUND) begin
          term_k = k; ecode = 2'd0;
        end else if (solver_state == SOLVER_EXHAUSTED) begin
          term_k = k; ecode = 2'd1;
        end else if (k == LIMIT - 1) begin
          term_k = k; ecode = 2'd2;
        end
        if (term_k >= 0) enonce = nk;
        @(negedge clk);
        abort = 1'b0;
        if (term_k < 0) begin
          n_tests++;
          if (res_valid !== 1'b0 || solver_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL run_cycle %0d: res_valid=%b solver_rst_n=%b, required 0 1", k, res_valid, solver_rst_n);
          end
        end
      end
      solver_state = '0;
      solver_nonce = '0;
    end

    n_tests++;
    if (res_valid !== 1'b1 || solver_rst_n !== 1'b0 || res_code !== ecode || res_nonce !== enonce ||
        res_job_id !== 8'(exp_id) || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL report: valid=%b srst=%b code=%0d nonce=%h id=%0d in_ready=%b, required 1 0 %0d %h %0d 0",
               res_valid, solver_rst_n, res_code, res_nonce, res_job_id, in_ready, ecode, enonce, exp_id);
    end
    for (int i = 0; i < rd; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      n_tests++;
      if (res_valid !== 1'b1 || res_code !== ecode || res_nonce !== enonce ||
          res_job_id !== 8'(exp_id) || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL report_hold: valid=%b code=%0d nonce=%h id=%0d in_ready=%b, required 1 %0d %h %0d 0",
                 res_valid, res_code, res_nonce, res_job_id, in_ready, ecode, enonce, exp_id);
      end
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_id = (exp_id + 1) % 256;
    n_tests++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake: res_valid=%b in_ready=%b, required 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({solver_rst_n, in_ready, res_valid, res_code, res_nonce, res_job_id,
         midstate, target, header_leftovers} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: srst=%b in_ready=%b valid=%b code=%0d nonce=%h id=%0d, required all 0",
               solver_rst_n, in_ready, res_valid, res_code, res_nonce, res_job_id);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_id = 0;
  endtask

  task automatic test_found();
    logic [31:0] ref_words [JOB_WORDS] = '{
      32'h4a03aeb2, 32'h1c7e3f9a, 32'h5b8d2e61, 32'h0f4c7a93,
      32'he2d91b58, 32'h7a6c0e34, 32'h93b5f2d7, 32'hddef7254,
      32'h00000000, 32'h00000000, 32'h000440c4, 32'h00000000,
      32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
      32'h15274c64, 32'h6c51f957, 32'hc4400418};
    for (int i = 0; i < JOB_WORDS; i++) jw[i] = ref_words[i];
    run_job(0, 5, 1, 1'b0, 32'h9c9a4fc0);
  endtask

  task automatic test_exhausted();
    run_job(1, 3, 0, 1'b0, 32'hFFFF_FFFF);
  endtask

  task automatic test_timeout();
    run_job(2, 0, 2, 1'b1, 32'h0);
  endtask

  task automatic test_abort_load();
    random_job();
    run_job(5, 7, 1, 1'b0, 32'h0);
    random_job();
    run_job(0, 2, 0, 1'b1, $urandom);
  endtask

  task automatic test_abort_run_hold();
    random_job();
    run_job(3, 4, 1, 1'b0, 32'h0);
    random_job();
    run_job(4, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_backpressure();
    random_job();
    run_job(1, 6, 10, 1'b0, $urandom);
  endtask

  task automatic test_abort_idle();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle: res_valid=%b in_ready=%b, required 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_random();
    int kind;
    for (int n = 0; n < 12; n++) begin
      random_job();
      kind = $urandom_range(0, 5);
      run_job(kind, (kind == 5) ? $urandom_range(0, 17) : $urandom_range(0, 20),
              $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  task automatic test_async_reset();
    int c;
    random_job();
    for (int i = 0; i < JOB_WORDS; i++) send_word(jw[i], 1'b0);
    c = 0;
    while (solver_rst_n !== 1'b1 && c < 20) begin
      c++;
      @(negedge clk);
    end
    n_tests++;
    if (solver_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL async_run_entry: solver_rst_n=%b, required 1", solver_rst_n);
    end
    solver_state = 3'd1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({solver_rst_n, in_ready, res_valid, res_code, res_nonce, res_job_id,
         midstate, target, header_leftovers} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: srst=%b in_ready=%b valid=%b id=%0d ms=%h, required all 0",
               solver_rst_n, in_ready, res_valid, res_job_id, midstate);
    end
    solver_state = '0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_id = 0;
    random_job();
    run_job(0, 1, 0, 1'b1, $urandom);
  endtask

  initial begin
    test_reset();
    test_found();
    test_exhausted();
    test_timeout();
    test_abort_load();
    test_abort_run_hold();
    test_backpressure();
    test_abort_idle();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
